// File: rtl/ysyx_23060203_lsu.sv
// Load/store unit between EXU and WBU: one AXI4-Lite access per accepted instruction, registered writeback.
// Define LSU_PERF_EN to add the perf_load_cnt / perf_store_cnt / perf_wait_cyc counters.
module ysyx_23060203_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mem_ren,
    input  logic              in_mem_wen,
    input  logic [2:0]        in_funct3,
    input  logic [ADDR_W-1:0] in_mem_addr,
    input  logic [31:0]       in_mem_wdata,
    input  logic [4:0]        in_gpr_waddr,
    input  logic [31:0]       in_gpr_wdata,
    input  logic              in_csr_wen,
    input  logic [11:0]       in_csr_waddr,
    input  logic [31:0]       in_csr_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_gpr_waddr,
    output logic [31:0]       out_gpr_wdata,
    output logic              out_csr_wen,
    output logic [11:0]       out_csr_waddr,
    output logic [31:0]       out_csr_wdata,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
`ifdef LSU_PERF_EN
    output logic [31:0]       perf_load_cnt,
    output logic [31:0]       perf_store_cnt,
    output logic [31:0]       perf_wait_cyc,
`endif
    output logic              bready
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_e;

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [4:0]        out_gpr_waddr_q, out_gpr_waddr_d;
    logic [31:0]       out_gpr_wdata_q, out_gpr_wdata_d;
    logic              out_csr_wen_q, out_csr_wen_d;
    logic [11:0]       out_csr_waddr_q, out_csr_waddr_d;
    logic [31:0]       out_csr_wdata_q, out_csr_wdata_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              arvalid_q, arvalid_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        addr_lo_q, addr_lo_d;

    logic        accept;
    logic        is_load;
    logic        is_store;
    logic [1:0]  in_off;
    logic [3:0]  strb_base;
    logic [31:0] load_shifted;
    logic [31:0] load_ext;
    logic        unused_resp;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    // A request with both enables set is treated as a load.
    assign is_load  = in_mem_ren;
    assign is_store = in_mem_wen && !in_mem_ren;
    assign in_off   = in_mem_addr[1:0];
    assign unused_resp = ^{rresp, bresp};

    assign load_shifted = rdata >> {addr_lo_q, 3'b000};

    always_comb begin
        strb_base = 4'b1111;
        case (in_funct3[1:0])
            2'b00:   strb_base = 4'b0001;
            2'b01:   strb_base = 4'b0011;
            default: strb_base = 4'b1111;
        endcase
    end

    always_comb begin
        load_ext = load_shifted;
        case (funct3_q)
            3'b000:  load_ext = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b100:  load_ext = {24'b0, load_shifted[7:0]};
            3'b101:  load_ext = {16'b0, load_shifted[15:0]};
            default: load_ext = load_shifted;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        out_valid_d     = out_valid_q;
        out_gpr_waddr_d = out_gpr_waddr_q;
        out_gpr_wdata_d = out_gpr_wdata_q;
        out_csr_wen_d   = out_csr_wen_q;
        out_csr_waddr_d = out_csr_waddr_q;
        out_csr_wdata_d = out_csr_wdata_q;
        araddr_d        = araddr_q;
        awaddr_d        = awaddr_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        arvalid_d       = arvalid_q;
        awvalid_d       = awvalid_q;
        wvalid_d        = wvalid_q;
        aw_done_d       = aw_done_q;
        w_done_d        = w_done_q;
        funct3_d        = funct3_q;
        addr_lo_d       = addr_lo_q;

        // Consumed output is cleared; a same-cycle accept below overrides it.
        if (out_valid_q && out_ready) begin
            out_valid_d     = 1'b0;
            out_gpr_waddr_d = 5'd0;
            out_gpr_wdata_d = 32'd0;
            out_csr_wen_d   = 1'b0;
            out_csr_waddr_d = 12'd0;
            out_csr_wdata_d = 32'd0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    out_gpr_waddr_d = in_gpr_waddr;
                    out_gpr_wdata_d = in_gpr_wdata;
                    out_csr_wen_d   = in_csr_wen;
                    out_csr_waddr_d = in_csr_waddr;
                    out_csr_wdata_d = in_csr_wdata;
                    funct3_d        = in_funct3;
                    addr_lo_d       = in_off;
                    if (is_load) begin
                        araddr_d  = in_mem_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end else if (is_store) begin
                        awaddr_d        = in_mem_addr;
                        wdata_d         = in_mem_wdata << {in_off, 3'b000};
                        wstrb_d         = strb_base << in_off;
                        awvalid_d       = 1'b1;
                        wvalid_d        = 1'b1;
                        out_gpr_waddr_d = 5'd0;
                        state_d         = WR_REQ;
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end
            end
            RD_ADDR: begin
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    out_gpr_wdata_d = load_ext;
                    out_valid_d     = 1'b1;
                    state_d         = IDLE;
                end
            end
            WR_REQ: begin
                // AW and W channels finish independently, possibly in the same cycle.
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            out_valid_q     <= 1'b0;
            out_gpr_waddr_q <= 5'd0;
            out_gpr_wdata_q <= 32'd0;
            out_csr_wen_q   <= 1'b0;
            out_csr_waddr_q <= 12'd0;
            out_csr_wdata_q <= 32'd0;
            araddr_q        <= '0;
            awaddr_q        <= '0;
            wdata_q         <= 32'd0;
            wstrb_q         <= 4'd0;
            arvalid_q       <= 1'b0;
            awvalid_q       <= 1'b0;
            wvalid_q        <= 1'b0;
            aw_done_q       <= 1'b0;
            w_done_q        <= 1'b0;
            funct3_q        <= 3'd0;
            addr_lo_q       <= 2'd0;
        end else begin
            state_q         <= state_d;
            out_valid_q     <= out_valid_d;
            out_gpr_waddr_q <= out_gpr_waddr_d;
            out_gpr_wdata_q <= out_gpr_wdata_d;
            out_csr_wen_q   <= out_csr_wen_d;
            out_csr_waddr_q <= out_csr_waddr_d;
            out_csr_wdata_q <= out_csr_wdata_d;
            araddr_q        <= araddr_d;
            awaddr_q        <= awaddr_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            arvalid_q       <= arvalid_d;
            awvalid_q       <= awvalid_d;
            wvalid_q        <= wvalid_d;
            aw_done_q       <= aw_done_d;
            w_done_q        <= w_done_d;
            funct3_q        <= funct3_d;
            addr_lo_q       <= addr_lo_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_gpr_waddr = out_gpr_waddr_q;
    assign out_gpr_wdata = out_gpr_wdata_q;
    assign out_csr_wen   = out_csr_wen_q;
    assign out_csr_waddr = out_csr_waddr_q;
    assign out_csr_wdata = out_csr_wdata_q;
    assign araddr        = araddr_q;
    assign arvalid       = arvalid_q;
    assign rready        = (state_q == RD_DATA);
    assign awaddr        = awaddr_q;
    assign awvalid       = awvalid_q;
    assign wdata         = wdata_q;
    assign wstrb         = wstrb_q;
    assign wvalid        = wvalid_q;
    assign bready        = (state_q == WR_RESP);

`ifdef LSU_PERF_EN
    logic [31:0] perf_load_q, perf_store_q, perf_wait_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_load_q  <= 32'd0;
            perf_store_q <= 32'd0;
            perf_wait_q  <= 32'd0;
        end else begin
            if (rvalid && rready) perf_load_q <= perf_load_q + 32'd1;
            if (bvalid && bready) perf_store_q <= perf_store_q + 32'd1;
            if (state_q != IDLE) perf_wait_q <= perf_wait_q + 32'd1;
        end
    end

    assign perf_load_cnt  = perf_load_q;
    assign perf_store_cnt = perf_store_q;
    assign perf_wait_cyc  = perf_wait_q;
`endif

endmodule
